gat_bram_loader: RTL

- Stream-to-BRAM loader upstream of the GAT top wrapper.
- Accepts 32-bit words from a DMA-style valid/ready stream and writes them into one wrapper BRAM port A (h_data, h_node_info or wgt) using byte addressing: address increments by 4, and the wrapper uses address bits [ADDR_W+1:2].
- After the programmed word count is written, raises the matching *_bram_load_done level.
- One instance is used per BRAM.

---
 rtl/gat_bram_loader.sv | 132 +++++++++++++
 1 files changed

// File: rtl/gat_bram_loader.sv
// rtl/gat_bram_loader.sv - stream-to-BRAM word loader with byte addressing and load/error status
// Optional GAT_LOADER_DEBUG_EN builds a saturating count of accepted beats on o_dbg_words.
module gat_bram_loader #(
    parameter int DEPTH  = 242101,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_num_words,
    input  logic [31:0]       i_s_data,
    input  logic              i_s_valid,
    input  logic              i_s_last,
    output logic              o_s_ready,
    output logic [31:0]       o_bram_din,
    output logic              o_bram_ena,
    output logic              o_bram_wea,
    output logic [ADDR_W+1:0] o_bram_addra,
    output logic              o_load_done,
    output logic              o_busy,
    output logic              o_err_short,
    output logic              o_err_long,
    output logic [31:0]       o_dbg_words
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE, S_ERR} state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   r_target;
    logic [31:0]        r_din;
    logic               r_ena;
    logic               r_wea;
    logic [ADDR_W+1:0]  r_addra;
    logic               r_load_done;
    logic               r_err_short;
    logic               r_err_long;

    logic               w_final_beat;
    logic               w_bad_count;

    assign w_final_beat = (r_count == r_target - CNT_W'(1));
    assign w_bad_count  = (i_num_words == '0) || (i_num_words > CNT_W'(DEPTH));

    assign o_s_ready    = (r_state == S_LOAD);
    assign o_busy       = (r_state == S_LOAD);
    assign o_bram_din   = r_din;
    assign o_bram_ena   = r_ena;
    assign o_bram_wea   = r_wea;
    assign o_bram_addra = r_addra;
    assign o_load_done  = r_load_done;
    assign o_err_short  = r_err_short;
    assign o_err_long   = r_err_long;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_target    <= '0;
            r_din       <= '0;
            r_ena       <= 1'b0;
            r_wea       <= 1'b0;
            r_addra     <= '0;
            r_load_done <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
        end else begin
            r_ena <= 1'b0;
            r_wea <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    // The beat is written even when it ends the load early or late.
                    if (i_s_valid) begin
                        r_ena   <= 1'b1;
                        r_wea   <= 1'b1;
                        r_din   <= i_s_data;
                        r_addra <= {r_count[ADDR_W-1:0], 2'b00};
                        r_count <= r_count + CNT_W'(1);
                        if (w_final_beat) begin
                            r_state <= S_DONE;
                            if (!i_s_last) begin
                                r_err_long <= 1'b1;
                            end
                        end else if (i_s_last) begin
                            r_state     <= S_ERR;
                            r_err_short <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (i_start) begin
                        r_load_done <= 1'b0;
                        if (w_bad_count) begin
                            r_state     <= S_ERR;
                            r_err_short <= 1'b1;
                        end else begin
                            r_state     <= S_LOAD;
                            r_target    <= i_num_words;
                            r_count     <= '0;
                            r_err_short <= 1'b0;
                            r_err_long  <= 1'b0;
                        end
                    end else begin
                        // One edge after entering DONE, so the flag trails the last write strobe.
                        r_load_done <= (r_state == S_DONE);
                    end
                end
            endcase
        end
    end

`ifdef GAT_LOADER_DEBUG_EN
    logic        w_accept;
    logic [31:0] r_dbg_words;

    assign w_accept = (r_state == S_LOAD) && i_s_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dbg_words <= '0;
        end else if (w_accept && (r_dbg_words != 32'hFFFF_FFFF)) begin
            r_dbg_words <= r_dbg_words + 32'd1;
        end
    end

    assign o_dbg_words = r_dbg_words;
`else
    assign o_dbg_words = '0;
`endif

endmodule
